// File: rtl/sdc_cmd_sequencer.sv
// sdc_cmd_sequencer
//   Wishbone master that runs one SD command at a time against the
//   sdc_controller register file. For each command it:
//     1. writes ARGUMENT (0x00)
//     2. writes COMMAND (0x04)
//     3. polls CMD_EVENT_STATUS (0x34)
//     4. reads RESPONSE_0..3 (0x08..0x14) as the response type requires
//     5. clears CMD_EVENT_STATUS
//   It then pulses rsp_valid with the collected status and response words.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_index/arg/rsp_type/xfer_dir   command fields, latched on accept
//   busy                   accept cycle through the rsp_valid cycle
//   rsp_valid/status/data  completion pulse, status byte, response words
//   wb_*                   Wishbone master interface
module sdc_cmd_sequencer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int POLL_GAP    = 16,
   parameter int POLL_LIMIT  = 1024,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [5:0]            cmd_index,
   input  logic [31:0]           cmd_arg,
   input  logic [3:0]            cmd_rsp_type,
   input  logic [1:0]            cmd_xfer_dir,
   output logic                  busy,
   output logic                  rsp_valid,
   output logic [7:0]            rsp_status,
   output logic [127:0]          rsp_data,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [31:0]           wb_dat_o,
   input  logic [31:0]           wb_dat_i,
   output logic [3:0]            wb_sel_o,
   output logic                  wb_we_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   input  logic                  wb_ack_i
);
   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam int AW = $clog2(ACK_TIMEOUT + 1);
   localparam int GW = $clog2(POLL_GAP + 1);

   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
   localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);
   localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
   localparam logic [AW-1:0] ACK_MAX   = AW'(ACK_TIMEOUT);
   localparam logic [GW-1:0] WAIT_LAST = GW'(POLL_GAP - 1);
   localparam logic [GW-1:0] WAIT_MAX  = GW'(POLL_GAP);

   localparam logic [7:0] OFF_ARG    = 8'h00;
   localparam logic [7:0] OFF_CMD    = 8'h04;
   localparam logic [7:0] OFF_RSP0   = 8'h08;
   localparam logic [7:0] OFF_STATUS = 8'h34;

   typedef enum logic [2:0] {
      IDLE, WR_ARG, WR_CMD, POLL_WAIT, POLL_RD, RD_RSP, CLEAR, DONE
   } state_t;

   state_t state_reg, state_next;

   logic            post_ack_reg;   // forces the idle cycle after every ack
   logic [AW-1:0]   ack_cnt_reg;
   logic [PW-1:0]   poll_cnt_reg;
   logic [GW-1:0]   wait_cnt_reg;
   logic [1:0]      word_idx_reg;
   logic [31:0]     arg_reg;
   logic [5:0]      index_reg;
   logic [3:0]      rsp_type_reg;
   logic [1:0]      dir_reg;
   logic [6:0]      status_reg;     // [4:0] event status, [5] poll t/o, [6] bus t/o
   logic [127:0]    data_reg;

   logic            accept;
   logic            access_state;
   logic            cyc;
   logic            ack;
   logic            ack_expired;
   logic            last_word;
   logic [31:0]     cmd_word;
   logic [7:0]      offset;
   logic [31:0]     wdata;
   logic            wr_en;

   assign accept       = cmd_valid && (state_reg == IDLE);
   assign access_state = state_reg inside {WR_ARG, WR_CMD, POLL_RD, RD_RSP, CLEAR};
   // The bus is driven straight from the state so reset drops it at once.
   assign cyc          = access_state && !post_ack_reg;
   assign ack          = cyc && wb_ack_i;
   assign ack_expired  = cyc && !wb_ack_i && (ack_cnt_reg == ACK_LAST);
   assign last_word    = !rsp_type_reg[1] || (word_idx_reg == 2'd3);
   assign cmd_word     = {19'd0, index_reg, 1'b0, dir_reg, rsp_type_reg};

   always_comb begin
      state_next = state_reg;
      offset     = 8'h00;
      wdata      = 32'd0;
      wr_en      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = WR_ARG;
         end
         WR_ARG: begin
            offset = OFF_ARG;
            wdata  = arg_reg;
            wr_en  = 1'b1;
            if (ack) state_next = WR_CMD;
         end
         WR_CMD: begin
            offset = OFF_CMD;
            wdata  = cmd_word;
            wr_en  = 1'b1;
            if (ack) state_next = POLL_WAIT;
         end
         POLL_WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) state_next = POLL_RD;
         end
         POLL_RD: begin
            offset = OFF_STATUS;
            if (ack) begin
               // Error bits take priority over completion.
               if (wb_dat_i[4:1] != 4'd0)
                  state_next = CLEAR;
               else if (wb_dat_i[0])
                  state_next = rsp_type_reg[0] ? RD_RSP : CLEAR;
               else if (poll_cnt_reg == POLL_LAST)
                  state_next = CLEAR;
               else
                  state_next = POLL_WAIT;
            end
         end
         RD_RSP: begin
            offset = OFF_RSP0 + {4'd0, word_idx_reg, 2'b00};
            if (ack && last_word) state_next = CLEAR;
         end
         CLEAR: begin
            offset = OFF_STATUS;
            wr_en  = 1'b1;
            if (ack) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // A stalled access abandons the command without the clear write.
      if (ack_expired) state_next = DONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         post_ack_reg <= 1'b0;
         ack_cnt_reg  <= '0;
         poll_cnt_reg <= '0;
         wait_cnt_reg <= '0;
         word_idx_reg <= 2'd0;
         arg_reg      <= 32'd0;
         index_reg    <= 6'd0;
         rsp_type_reg <= 4'd0;
         dir_reg      <= 2'd0;
         status_reg   <= 7'd0;
         data_reg     <= 128'd0;
      end else begin
         state_reg    <= state_next;
         post_ack_reg <= ack;

         if (cyc && !wb_ack_i) begin
            if (ack_cnt_reg != ACK_MAX) ack_cnt_reg <= ack_cnt_reg + AW'(1);
         end else begin
            ack_cnt_reg <= '0;
         end

         if (state_reg == POLL_WAIT) begin
            if (wait_cnt_reg != WAIT_MAX) wait_cnt_reg <= wait_cnt_reg + GW'(1);
         end else begin
            wait_cnt_reg <= '0;
         end

         if (accept) begin
            arg_reg      <= cmd_arg;
            index_reg    <= cmd_index;
            rsp_type_reg <= cmd_rsp_type;
            dir_reg      <= cmd_xfer_dir;
            status_reg   <= 7'd0;
            data_reg     <= 128'd0;
            poll_cnt_reg <= '0;
            word_idx_reg <= 2'd0;
         end

         if (ack && (state_reg == POLL_RD)) begin
            status_reg[4:0] <= wb_dat_i[4:0];
            if (poll_cnt_reg != POLL_MAX) poll_cnt_reg <= poll_cnt_reg + PW'(1);
            // Completion on the final allowed read is a success, not a timeout.
            if ((wb_dat_i[4:0] == 5'd0) && (poll_cnt_reg == POLL_LAST))
               status_reg[5] <= 1'b1;
         end

         if (ack && (state_reg == RD_RSP)) begin
            data_reg[32*word_idx_reg +: 32] <= wb_dat_i;
            word_idx_reg                    <= word_idx_reg + 2'd1;
         end

         if (ack_expired) status_reg[6] <= 1'b1;
      end
   end

   assign cmd_ready  = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE) || accept;
   assign rsp_valid  = (state_reg == DONE);
   assign rsp_status = {(status_reg[4:1] != 4'd0) || status_reg[5] || status_reg[6],
                        status_reg};
   assign rsp_data   = data_reg;

   assign wb_cyc_o = cyc;
   assign wb_stb_o = cyc;
   assign wb_sel_o = {4{cyc}};
   assign wb_we_o  = cyc && wr_en;
   assign wb_adr_o = cyc ? ADDR_WIDTH'(offset) : '0;
   assign wb_dat_o = cyc ? wdata : 32'd0;

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// tb_sdc_cmd_sequencer
//   Drives commands into sdc_cmd_sequencer against a behavioural Wishbone
//   slave with random ack latency and stray acks while idle. Expected bus
//   traffic, status byte and response words come from a command-level
//   model of the poll / response rules.
`timescale 1ns/1ps
module tb_sdc_cmd_sequencer;
   localparam int PG = 3;
   localparam int PL = 4;
   localparam int AT = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [5:0]    cmd_index;
   logic [31:0]   cmd_arg;
   logic [3:0]    cmd_rsp_type;
   logic [1:0]    cmd_xfer_dir;
   logic          busy;
   logic          rsp_valid;
   logic [7:0]    rsp_status;
   logic [127:0]  rsp_data;
   logic [7:0]    wb_adr_o;
   logic [31:0]   wb_dat_o;
   logic [31:0]   wb_dat_i;
   logic [3:0]    wb_sel_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          wb_ack_i;

   always #5 clk = ~clk;

   sdc_cmd_sequencer #(
      .ADDR_WIDTH(8), .POLL_GAP(PG), .POLL_LIMIT(PL), .ACK_TIMEOUT(AT)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
      .cmd_arg(cmd_arg), .cmd_rsp_type(cmd_rsp_type), .cmd_xfer_dir(cmd_xfer_dir),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
   );

   typedef struct packed {
      logic [7:0]  adr;
      logic        we;
      logic [31:0] dat;
      logic [15:0] idle;
   } acc_t;

   acc_t log_q[$];
   int   errors = 0;
   int   checks = 0;

   // slave script for the command in flight
   int          s_k = 1;
   logic [31:0] s_v = 32'd0;
   logic [31:0] s_resp [4];
   logic        s_noack = 1'b0;
   int          s_poll = 0;
   int          s_waited = 0;
   int          s_lat = 0;

   // monitor state
   logic        m_prev_cyc = 1'b0;
   logic        m_prev_ack = 1'b0;
   logic [40:0] m_prev_bus = '0;
   int          m_run = 0;
   int          m_abort_len = 0;
   int          m_idle = 0;
   int          m_cur_idle = 0;
   int          viol = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic slave_read(input logic [7:0] a, output logic [31:0] d);
      int idx;
      if (a == 8'h34) begin
         s_poll++;
         if (s_poll < s_k) begin
            d      = $urandom;
            d[4:0] = 5'd0;
         end else begin
            d = s_v;
         end
      end else if (a >= 8'h08 && a <= 8'h14) begin
         idx = (int'(a) - 8) / 4;
         d   = s_resp[idx];
      end else begin
         d = $urandom;
      end
   endtask

   initial begin : slave
      wb_ack_i = 1'b0;
      wb_dat_i = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            wb_ack_i = 1'b0;
            s_waited = 0;
         end else if (wb_cyc_o && !wb_ack_i) begin
            if (s_waited >= s_lat && !(s_noack && wb_adr_o == 8'h04)) begin
               wb_ack_i = 1'b1;
               if (!wb_we_o) slave_read(wb_adr_o, wb_dat_i);
               s_waited = 0;
               s_lat    = $urandom_range(0, 2);
            end else begin
               wb_ack_i = 1'b0;
               s_waited++;
            end
         end else begin
            wb_ack_i = !wb_cyc_o && ($urandom_range(0, 7) == 0);
            wb_dat_i = $urandom;
         end
      end
   end

   initial begin : monitor
      acc_t a;
      forever begin
         @(negedge clk);
         if (wb_cyc_o) begin
            if (wb_sel_o != 4'hF || !wb_stb_o) viol++;
            if (m_prev_cyc && m_prev_ack) viol++;
            if (m_prev_cyc && !m_prev_ack && {wb_adr_o, wb_we_o, wb_dat_o} != m_prev_bus) viol++;
            if (!m_prev_cyc || m_prev_ack) begin
               m_run      = 1;
               m_cur_idle = m_idle;
               m_idle     = 0;
            end else begin
               m_run++;
            end
            if (wb_ack_i) begin
               a.adr  = wb_adr_o;
               a.we   = wb_we_o;
               a.dat  = wb_we_o ? wb_dat_o : wb_dat_i;
               a.idle = 16'(m_cur_idle);
               log_q.push_back(a);
            end
         end else begin
            if (wb_sel_o != 4'h0 || wb_stb_o || wb_we_o) viol++;
            if (m_prev_cyc && !m_prev_ack) m_abort_len = m_run;
            m_idle++;
         end
         m_prev_cyc = wb_cyc_o;
         m_prev_ack = wb_cyc_o && wb_ack_i;
         m_prev_bus = {wb_adr_o, wb_we_o, wb_dat_o};
      end
   end

   task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [3:0] rt, input logic [1:0] dir);
      int n = 0;
      s_poll = 0;
      log_q.delete();
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("cmd_ready_idle", cmd_ready, 1);
      cmd_valid    = 1'b1;
      cmd_index    = idx;
      cmd_arg      = arg;
      cmd_rsp_type = rt;
      cmd_xfer_dir = dir;
      #1;
      check_val("busy_accept", busy, 1);
      @(posedge clk);
      #1;
      cmd_valid    = 1'b0;
      cmd_index    = 6'($urandom);
      cmd_arg      = $urandom;
      cmd_rsp_type = 4'($urandom);
      cmd_xfer_dir = 2'($urandom);
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [3:0] rt,
                          input logic [1:0] dir, input int k, input logic [31:0] v,
                          input logic noack, input string name);
      acc_t         exp_q[$];
      acc_t         e;
      logic [4:0]   st = 5'd0;
      logic         tp = 1'b0;
      logic         ta = 1'b0;
      int           words = 0;
      logic [127:0] exp_data = '0;
      logic [7:0]   exp_status;
      int           n = 0;
      int           lim;

      s_k = k;
      s_v = v;
      s_noack = noack;
      for (int w = 0; w < 4; w++) s_resp[w] = $urandom;

      // command-level model
      e = '0;
      e.adr = 8'h00; e.we = 1'b1; e.dat = arg;
      exp_q.push_back(e);
      if (noack) begin
         ta = 1'b1;
      end else begin
         e.adr = 8'h04; e.we = 1'b1; e.dat = {19'd0, idx, 1'b0, dir, rt};
         exp_q.push_back(e);
         for (int r = 1; r <= PL; r++) begin
            e.adr = 8'h34; e.we = 1'b0; e.dat = 32'd0;
            exp_q.push_back(e);
            st = (r < k) ? 5'd0 : v[4:0];
            if (st[4:1] != 4'd0) break;
            if (st[0]) begin
               if (rt[0]) words = rt[1] ? 4 : 1;
               break;
            end
            if (r == PL) tp = 1'b1;
         end
         for (int w = 0; w < words; w++) begin
            e.adr = 8'(8 + 4 * w); e.we = 1'b0; e.dat = 32'd0;
            exp_q.push_back(e);
            exp_data[32*w +: 32] = s_resp[w];
         end
         e.adr = 8'h34; e.we = 1'b1; e.dat = 32'd0;
         exp_q.push_back(e);
      end
      exp_status = {(st[4:1] != 4'd0) || tp || ta, ta, tp, st};

      start_cmd(idx, arg, rt, dir);
      while (!rsp_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_val({name, ":rsp_valid"}, rsp_valid, 1);
      if (!rsp_valid) return;
      check_val({name, ":busy_done"}, busy, 1);
      check_val({name, ":status"}, rsp_status, exp_status);
      check_val({name, ":data"}, rsp_data, exp_data);
      check_val({name, ":n_access"}, log_q.size(), exp_q.size());
      lim = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++) begin
         check_val({name, ":adr"}, log_q[i].adr, exp_q[i].adr);
         check_val({name, ":we"}, log_q[i].we, exp_q[i].we);
         if (exp_q[i].we) check_val({name, ":wdata"}, log_q[i].dat, exp_q[i].dat);
         if (exp_q[i].adr == 8'h34 && !exp_q[i].we)
            check_val({name, ":poll_gap"}, log_q[i].idle, PG);
         else if (i > 0)
            check_val({name, ":idle_gap"}, (log_q[i].idle >= 1), 1);
      end
      $display("cmd %s idx=%0d arg=%h rt=%b dir=%b status=%h data=%h",
               name, idx, arg, rt, dir, rsp_status, rsp_data);
      @(negedge clk);
      check_val({name, ":pulse_end"}, rsp_valid, 0);
      check_val({name, ":ready_after"}, cmd_ready, 1);
      check_val({name, ":status_held"}, rsp_status, exp_status);
      if (noack) check_val({name, ":ack_window"}, m_abort_len, AT);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [31:0] v;
      int n;
      reset        = 1'b1;
      cmd_valid    = 1'b0;
      cmd_index    = 6'd0;
      cmd_arg      = 32'd0;
      cmd_rsp_type = 4'd0;
      cmd_xfer_dir = 2'd0;
      repeat (3) @(negedge clk);
      check_val("rst_cmd_ready", cmd_ready, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_cyc", wb_cyc_o, 0);
      check_val("rst_stb", wb_stb_o, 0);
      check_val("rst_sel", wb_sel_o, 0);
      check_val("rst_status", rsp_status, 0);
      check_val("rst_data", rsp_data, 0);
      reset = 1'b0;
      @(negedge clk);

      run_cmd(6'd0, 32'd0, 4'b0000, 2'b00, 3, 32'h1, 1'b0, "cmd0");
      run_cmd(6'd2, 32'h0, 4'b0111, 2'b00, 1, 32'h1, 1'b0, "cmd2");
      run_cmd(6'd17, 32'h200, 4'b0101, 2'b01, 2, 32'h1, 1'b0, "cmd17");
      run_cmd(6'd13, 32'h1234, 4'b0111, 2'b00, 1, 32'h5, 1'b0, "err_win");
      run_cmd(6'd8, 32'h1AA, 4'b0101, 2'b00, 99, 32'h0, 1'b0, "poll_to");
      run_cmd(6'd17, 32'h4, 4'b0101, 2'b01, PL, 32'h1, 1'b0, "last_poll_ok");
      run_cmd(6'd55, 32'hDEAD, 4'b0101, 2'b00, 1, 32'h1, 1'b1, "ack_to");

      // reset in the middle of the response reads
      s_k = 1; s_v = 32'h1; s_noack = 1'b0;
      start_cmd(6'd2, 32'h0, 4'b0111, 2'b00);
      n = 0;
      while (!(wb_cyc_o && wb_adr_o == 8'h0C) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_val("mid_rsp_reached", (wb_cyc_o && wb_adr_o == 8'h0C), 1);
      #1 reset = 1'b1;
      #1;
      check_val("abort_cyc", wb_cyc_o, 0);
      check_val("abort_stb", wb_stb_o, 0);
      check_val("abort_rsp_valid", rsp_valid, 0);
      check_val("abort_ready", cmd_ready, 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("post_rst_ready", cmd_ready, 1);
      check_val("post_rst_status", rsp_status, 0);
      check_val("post_rst_data", rsp_data, 0);
      check_val("post_rst_rsp_valid", rsp_valid, 0);
      run_cmd(6'd9, 32'hABCD0000, 4'b0111, 2'b00, 2, 32'h1, 1'b0, "after_rst");

      for (int t = 0; t < 40; t++) begin
         v = $urandom;
         if ($urandom_range(0, 1) == 1) v[4:0] = 5'h01;
         run_cmd(6'($urandom), $urandom, 4'($urandom), 2'($urandom),
                 $urandom_range(1, PL + 1), v, 1'b0, "rand");
      end

      check_val("bus_protocol", viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
